bram_pipe: RTL and testbench

BRAM_PIPE -- requirements
Module: bram_pipe

---
 rtl/bram_pkg.sv | 12 +
 rtl/bram_core.sv | 46 ++++
 rtl/bram_pipe.sv | 164 ++++++++++++++++
 tb/tb_bram_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and FSM encoding for the pipelined block-RAM wrapper.
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/bram_core.sv
// Byte-enable write port plus registered read port; the read register can take
// individual lanes from the concurrent write data when the wrapper asks for it.
module bram_core
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH/8-1:0] byp,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read-first output register with per-lane bypass of the incoming write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < NB; i++) begin
        rdata[i*8 +: 8] <= byp[i] ? wdata[i*8 +: 8] : mem[raddr][i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/bram_pipe.sv
// Block-RAM wrapper: zero-fill sweep FSM, read-during-write policy and a
// one- or two-stage read pipeline, all frozen by the global clock enable.
module bram_pipe
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  input  logic                    init,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("bram_pipe: DATA_WIDTH must be a positive multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_pipe: READ_LATENCY must be 1 or 2");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;
  logic                    core_we;
  logic [NB-1:0]           core_be;
  logic [ADDR_WIDTH-1:0]   core_waddr;
  logic [DATA_WIDTH-1:0]   core_wdata;
  logic                    core_re;
  logic [NB-1:0]           core_byp;
  logic [DATA_WIDTH-1:0]   core_rdata;
  logic                    v1;

  // Next-state, sweep address and memory port steering.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    core_we    = 1'b0;
    core_be    = '0;
    core_waddr = write_address;
    core_wdata = data_in;
    core_re    = 1'b0;
    core_byp   = '0;
    if (en) begin
      case (state)
        ST_CLEAR: begin
          core_we    = 1'b1;
          core_be    = {NB{1'b1}};
          core_waddr = cnt;
          core_wdata = '0;
          cnt_nxt    = cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) begin
            state_nxt = ST_READY;
          end else begin
            state_nxt = ST_CLEAR;
          end
        end
        ST_READY: begin
          core_we = we;
          core_be = be;
          core_re = rd_req;
          // New-data mode: lanes being written now are forwarded into the read register.
          if (RDW_MODE == RDW_NEW && we && rd_req && (write_address == read_address)) begin
            core_byp = be;
          end else begin
            core_byp = '0;
          end
          if (init) begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_READY;
          end
        end
        default: begin
          state_nxt = RST_STATE;
          cnt_nxt   = '0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // First pipeline stage: valid flag tracking the core read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= core_re;
    end
  end

  bram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .be    (core_be),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (read_address),
    .byp   (core_byp),
    .rdata (core_rdata)
  );

  if (READ_LATENCY == 1) begin : g_lat1
    assign data_out = core_rdata;
    assign rd_valid = v1;
  end else begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    // Second stage: copies the core register only when it carries a result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1) begin
          d2 <= core_rdata;
        end
      end
    end

    assign data_out = d2;
    assign rd_valid = v2;
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_bram_pipe.sv
// Directed bench: two instances share stimulus, one latency-1/old-data and one
// latency-2/new-data, each checked against hand-computed values.
module tb_bram_pipe;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  waddr;
  logic [31:0] din;
  logic        rd_req;
  logic [3:0]  raddr;
  logic        init;

  logic [31:0] a_dout;
  logic        a_vld;
  logic        a_busy;
  logic [31:0] b_dout;
  logic        b_vld;
  logic        b_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  bram_pipe #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .write_address(waddr),
    .data_in(din), .rd_req(rd_req), .read_address(raddr), .init(init),
    .data_out(a_dout), .rd_valid(a_vld), .busy(a_busy)
  );

  bram_pipe #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .write_address(waddr),
    .data_in(din), .rd_req(rd_req), .read_address(raddr), .init(init),
    .data_out(b_dout), .rd_valid(b_vld), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; we = 1'b0; be = 4'h0; rd_req = 1'b0; init = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    idle();
    we = 1'b1; waddr = a; din = d; be = b;
    tick();
    idle();
  endtask

  initial begin
    rst_n = 1'b0; idle(); waddr = 4'h0; din = 32'h0; raddr = 4'h0;
    tick(); tick();
    chk("rst_a_busy", a_busy, 1'b1);
    chk("rst_b_busy", b_busy, 1'b1);
    chk("rst_a_vld", a_vld, 1'b0);
    chk("rst_a_dout", a_dout, 32'h0);
    chk("rst_b_vld", b_vld, 1'b0);
    chk("rst_b_dout", b_dout, 32'h0);

    // power-up sweep length
    rst_n = 1'b1;
    n = 0;
    while (a_busy && n < 40) begin tick(); n++; end
    chk("sweep_len", n, 32'd16);
    chk("sweep_b_busy", b_busy, 1'b0);

    // every word reads back as zero
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1; raddr = 4'(i);
      tick();
      chk("zero_a_vld", a_vld, 1'b1);
      chk("zero_a_dout", a_dout, 32'h0);
      if (i > 0) begin
        chk("zero_b_vld", b_vld, 1'b1);
        chk("zero_b_dout", b_dout, 32'h0);
      end
    end
    idle(); tick();
    chk("zero_tail_a_vld", a_vld, 1'b0);
    chk("zero_tail_b_vld", b_vld, 1'b1);
    tick();
    chk("zero_end_b_vld", b_vld, 1'b0);

    // byte-lane merge
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h00001100, 4'h2);
    wr(4'd3, 32'hFFFFFFFF, 4'h0);
    rd_req = 1'b1; raddr = 4'd3; tick(); idle();
    chk("be_a_vld", a_vld, 1'b1);
    chk("be_a_dout", a_dout, 32'hDEAD11EF);
    tick();
    chk("be_a_vld_drop", a_vld, 1'b0);
    chk("be_a_hold", a_dout, 32'hDEAD11EF);
    chk("be_b_vld", b_vld, 1'b1);
    chk("be_b_dout", b_dout, 32'hDEAD11EF);
    tick();
    chk("be_b_vld_drop", b_vld, 1'b0);
    chk("be_b_hold", b_dout, 32'hDEAD11EF);

    // back-to-back reads
    wr(4'd1, 32'h01010101, 4'hF);
    wr(4'd2, 32'h02020202, 4'hF);
    rd_req = 1'b1; raddr = 4'd1; tick();
    chk("b2b_a1", a_dout, 32'h01010101);
    chk("b2b_b_vld0", b_vld, 1'b0);
    raddr = 4'd2; tick();
    chk("b2b_a2", a_dout, 32'h02020202);
    chk("b2b_b_vld1", b_vld, 1'b1);
    chk("b2b_b1", b_dout, 32'h01010101);
    raddr = 4'd3; tick(); idle();
    chk("b2b_a3", a_dout, 32'hDEAD11EF);
    chk("b2b_b2", b_dout, 32'h02020202);
    tick();
    chk("b2b_b_vld3", b_vld, 1'b1);
    chk("b2b_b3", b_dout, 32'hDEAD11EF);
    tick();
    chk("b2b_b_vld_end", b_vld, 1'b0);

    // read-during-write, full word then partial lanes
    wr(4'd5, 32'h11111111, 4'hF);
    we = 1'b1; be = 4'hF; waddr = 4'd5; din = 32'h22222222; rd_req = 1'b1; raddr = 4'd5;
    tick();
    chk("rdw_a_old", a_dout, 32'h11111111);
    be = 4'h2; din = 32'h0000AB00;
    tick();
    chk("rdw_a_old2", a_dout, 32'h22222222);
    chk("rdw_b_new", b_dout, 32'h22222222);
    be = 4'hF; waddr = 4'd6; din = 32'h66666666; raddr = 4'd3;
    tick();
    chk("indep_a_rd", a_dout, 32'hDEAD11EF);
    chk("rdw_b_merge", b_dout, 32'h2222AB22);
    we = 1'b0; raddr = 4'd6;
    tick(); idle();
    chk("indep_a_wr", a_dout, 32'h66666666);
    chk("indep_b_rd", b_dout, 32'hDEAD11EF);
    tick();
    chk("indep_b_wr", b_dout, 32'h66666666);
    tick();

    // clock-enable stall
    rd_req = 1'b1; raddr = 4'd1; tick();
    chk("stall_a_pre", a_dout, 32'h01010101);
    en = 1'b0; rd_req = 1'b0; we = 1'b1; be = 4'hF; waddr = 4'd1; din = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_a_vld", a_vld, 1'b1);
      chk("stall_a_dout", a_dout, 32'h01010101);
      chk("stall_b_vld", b_vld, 1'b0);
      chk("stall_b_dout", b_dout, 32'h66666666);
    end
    idle(); tick();
    chk("stall_a_vld_after", a_vld, 1'b0);
    chk("stall_b_vld_after", b_vld, 1'b1);
    chk("stall_b_dout_after", b_dout, 32'h01010101);
    rd_req = 1'b1; raddr = 4'd1; tick(); idle();
    chk("stall_no_write", a_dout, 32'h01010101);
    tick(); tick();

    // init sweep with requests and a second init in flight
    wr(4'd7, 32'hA5A5A5A5, 4'hF);
    init = 1'b1; rd_req = 1'b1; raddr = 4'd7; tick();
    chk("init_a_pre", a_dout, 32'hA5A5A5A5);
    chk("init_a_busy", a_busy, 1'b1);
    chk("init_b_busy", b_busy, 1'b1);
    we = 1'b1; be = 4'hF; waddr = 4'd2; din = 32'hFFFFFFFF;
    n = 0;
    while (a_busy && n < 40) begin
      init = (n == 4);
      tick(); n++;
      chk("sweep_a_vld", a_vld, 1'b0);
      if (n == 1) begin
        chk("sweep_b_inflight", b_dout, 32'hA5A5A5A5);
        chk("sweep_b_vld1", b_vld, 1'b1);
      end else begin
        chk("sweep_b_vld", b_vld, 1'b0);
      end
    end
    chk("init_len", n, 32'd16);
    idle(); rd_req = 1'b1; raddr = 4'd7; tick();
    chk("init_addr7", a_dout, 32'h0);
    raddr = 4'd2; tick(); idle();
    chk("init_addr2", a_dout, 32'h0);
    chk("init_b_addr7", b_dout, 32'h0);

    // reset in the middle of a sweep restarts it
    init = 1'b1; tick(); init = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", a_busy, 1'b1);
    chk("mid_rst_a_dout", a_dout, 32'h0);
    chk("mid_rst_b_vld", b_vld, 1'b0);
    tick(); rst_n = 1'b1;
    n = 0;
    while (b_busy && n < 40) begin tick(); n++; end
    chk("mid_rst_len", n, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
